// File: rtl/io_pkg.sv
// io_pkg: shared types and constants for the transmit queue slice.
// Drain FSM state encoding plus the ASCII control bytes used by the
// optional CR insertion feature.

package io_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } tx_q_state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/io_tx_queue_if.sv
// io_tx_queue_if: producer push channel plus the uart_tx start/busy link.
// The master side is the environment (producer and uart_tx); the slave
// side is the queue itself.

interface io_tx_queue_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          wr_ready;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy;
   logic [CW-1:0] count;
   logic          empty;

   modport master (
      output wr_en, wr_data, tx_busy,
      input  wr_ready, tx_start, tx_data, count, empty
   );

   modport slave (
      input  wr_en, wr_data, tx_busy,
      output wr_ready, tx_start, tx_data, count, empty
   );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: byte FIFO with wrap-bit pointers.
// Pointers are one bit wider than the address so that full and empty can
// be told apart; they wrap naturally modulo 2*DEPTH. Push while full and
// pop while empty are ignored here as a second line of defence.

module sync_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic [7:0]             head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic [7:0]  mem_r [DEPTH];
   logic        do_push_s;
   logic        do_pop_s;

   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign count = wr_ptr_r - rd_ptr_r;
   assign head  = mem_r[rd_ptr_r[AW-1:0]];

   // Qualify requests against the registered full/empty flags.
   always_comb begin
      do_push_s = push & ~full;
      do_pop_s  = pop & ~empty;
   end

   // Pointer registers; cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/io_tx_queue.sv
// io_tx_queue: buffered transmit front-end for uart_tx.
// Bytes are pushed through a valid/ready channel into sync_fifo, and a
// drain FSM turns them into one-cycle tx_start pulses paced by tx_busy.
// Optional build macro IO_TX_QUEUE_CRLF_EN: each LF is preceded on the
// line by a CR that is generated here and never stored in the FIFO.

module io_tx_queue #(
   parameter int DEPTH     = 16,
   parameter int ACK_GUARD = 3
) (
   input logic          clk,
   input logic          rst,
   io_tx_queue_if.slave bus
);
   import io_pkg::*;

   localparam int             CW         = $clog2(DEPTH) + 1;
   localparam int             GW         = $clog2(ACK_GUARD + 1);
   localparam logic [GW-1:0]  GUARD_LAST = GW'(ACK_GUARD - 1);

   tx_q_state_t   state_r;
   tx_q_state_t   state_s;
   logic          tx_start_r;
   logic          tx_start_s;
   logic [7:0]    tx_data_r;
   logic [7:0]    tx_data_s;
   logic [GW-1:0] guard_r;
   logic [GW-1:0] guard_s;
   logic          push_s;
   logic          pop_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic [7:0]    head_s;
   logic [CW-1:0] fifo_count_s;
`ifdef IO_TX_QUEUE_CRLF_EN
   logic          crlf_pending_r;
   logic          crlf_pending_s;
`endif

   // wr_ready comes from registered pointers, so a pop on the same edge
   // never opens room for a push while full.
   assign push_s       = bus.wr_en & ~fifo_full_s;
   assign bus.wr_ready = ~fifo_full_s;
   assign bus.count    = fifo_count_s;
   assign bus.empty    = fifo_empty_s;
   assign bus.tx_start = tx_start_r;
   assign bus.tx_data  = tx_data_r;

   sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (bus.wr_data),
      .pop       (pop_s),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Drain FSM next-state and next-output logic.
   always_comb begin
      state_s    = state_r;
      tx_start_s = 1'b0;
      tx_data_s  = tx_data_r;
      guard_s    = guard_r;
      pop_s      = 1'b0;
`ifdef IO_TX_QUEUE_CRLF_EN
      crlf_pending_s = crlf_pending_r;
`endif
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s && !bus.tx_busy) begin
               state_s    = START;
               tx_start_s = 1'b1;
`ifdef IO_TX_QUEUE_CRLF_EN
               if ((head_s == ASCII_LF) && !crlf_pending_r) begin
                  tx_data_s      = ASCII_CR;
                  crlf_pending_s = 1'b1;
               end else begin
                  tx_data_s      = head_s;
                  crlf_pending_s = 1'b0;
                  pop_s          = 1'b1;
               end
`else
               tx_data_s  = head_s;
               pop_s      = 1'b1;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            state_s = WAIT_ACK;
            guard_s = {GW{1'b0}};
         end
         WAIT_ACK: begin
            if (bus.tx_busy) begin
               state_s = WAIT_DONE;
            end else if (guard_r == GUARD_LAST) begin
               // uart_tx never acknowledged; give up and move on.
               state_s = IDLE;
            end else begin
               guard_s = guard_r + GW'(1);
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Drain FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         tx_start_r <= 1'b0;
         tx_data_r  <= 8'h00;
         guard_r    <= {GW{1'b0}};
`ifdef IO_TX_QUEUE_CRLF_EN
         crlf_pending_r <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         tx_start_r <= tx_start_s;
         tx_data_r  <= tx_data_s;
         guard_r    <= guard_s;
`ifdef IO_TX_QUEUE_CRLF_EN
         crlf_pending_r <= crlf_pending_s;
`endif
      end
   end

endmodule

// File: tb/tb_io_tx_queue.sv
// tb_io_tx_queue: directed bench for io_tx_queue with a byte scoreboard.
// Accepted pushes queue their expected line bytes; a negedge monitor pops
// and compares on every tx_start pulse and also plays the uart_tx role.

module tb_io_tx_queue;
   import io_pkg::*;

   localparam int DEPTH     = 4;
   localparam int ACK_GUARD = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   io_tx_queue_if #(.DEPTH(DEPTH)) bus_if ();

   io_tx_queue #(
      .DEPTH     (DEPTH),
      .ACK_GUARD (ACK_GUARD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   int         checks   = 0;
   int         failures = 0;
   int         pulses   = 0;
   logic [7:0] exp_q[$];

   int   busy_len   = 5;
   logic stuck_busy = 1'b0;
   int   model_cnt  = 0;
   logic model_busy = 1'b0;
   logic prev_start = 1'b0;

   assign bus_if.tx_busy = model_busy | stuck_busy;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard plus uart_tx model, all on the falling edge.
   always @(negedge clk) begin
      logic [7:0] exp_b;
      if (bus_if.tx_start) begin
         pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse actual=%0h expected=none", bus_if.tx_data);
         end else begin
            exp_b = exp_q.pop_front();
            if (bus_if.tx_data !== exp_b) begin
               failures++;
               $display("FAIL tx_data actual=%0h expected=%0h", bus_if.tx_data, exp_b);
            end
         end
         checks++;
         if (bus_if.tx_busy) begin
            failures++;
            $display("FAIL pulse_while_busy actual=1 expected=0");
         end
         checks++;
         if (prev_start) begin
            failures++;
            $display("FAIL pulse_width actual=2+ expected=1");
         end
      end
      prev_start <= bus_if.tx_start;
      if (bus_if.tx_start && (busy_len > 0)) begin
         model_cnt  <= busy_len;
         model_busy <= 1'b1;
      end else if (model_cnt > 1) begin
         model_cnt  <= model_cnt - 1;
      end else begin
         model_cnt  <= 0;
         model_busy <= 1'b0;
      end
   end

   // Offer a byte (called at a negedge); returns at the negedge after acceptance.
   task automatic push_byte(input logic [7:0] b);
      int waited = 0;
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = b;
      while (!bus_if.wr_ready && (waited < 200)) begin
         @(negedge clk);
         waited++;
      end
      if (!bus_if.wr_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout actual=blocked expected=accepted byte=%0h", b);
         bus_if.wr_en = 1'b0;
      end else begin
`ifdef IO_TX_QUEUE_CRLF_EN
         if (b == ASCII_LF) begin
            exp_q.push_back(ASCII_CR);
         end
`endif
         exp_q.push_back(b);
         @(negedge clk);
      end
   endtask

   task automatic release_wr();
      bus_if.wr_en = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (((exp_q.size() != 0) || bus_if.tx_busy || !bus_if.empty) && (n < 3000)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ((exp_q.size() != 0) || bus_if.tx_busy || !bus_if.empty) begin
         failures++;
         $display("FAIL %s actual=pending(%0d) expected=drained", name, exp_q.size());
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      int n;
      bus_if.wr_en   = 1'b0;
      bus_if.wr_data = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_count",    32'(bus_if.count),    32'd0);
      check("rst_empty",    32'(bus_if.empty),    32'd1);
      check("rst_wr_ready", 32'(bus_if.wr_ready), 32'd1);
      check("rst_tx_start", 32'(bus_if.tx_start), 32'd0);
      check("rst_tx_data",  32'(bus_if.tx_data),  32'h00);

      // Single byte: pulse one cycle after acceptance
      busy_len = 5;
      push_byte(8'h41);
      release_wr();
      check("single_count",  32'(bus_if.count), 32'd1);
      check("single_empty0", 32'(bus_if.empty), 32'd0);
      @(negedge clk);
      check("single_start",  32'(bus_if.tx_start), 32'd1);
      check("single_data",   32'(bus_if.tx_data),  32'h41);
      check("single_empty1", 32'(bus_if.empty),    32'd1);
      wait_drain("single_drain");

      // Burst 0x01..0x05 with a 20-cycle frame
      busy_len = 20;
      p0 = pulses;
      for (int i = 1; i <= 5; i++) begin
         push_byte(8'(i));
      end
      release_wr();
      check("burst_count",    32'(bus_if.count),    32'd4);
      check("burst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
      wait_drain("burst_drain");
      check("burst_pulses", 32'(pulses - p0), 32'd5);

      // Full boundary with busy stuck high
      busy_len   = 4;
      stuck_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_byte(8'h11 + 8'(i));
      end
      release_wr();
      check("full_wr_ready", 32'(bus_if.wr_ready), 32'd0);
      check("full_count",    32'(bus_if.count),    32'd4);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = 8'h15;
      repeat (5) @(negedge clk);
      check("full_hold_count", 32'(bus_if.count),    32'd4);
      check("full_hold_ready", 32'(bus_if.wr_ready), 32'd0);
      stuck_busy = 1'b0;
      push_byte(8'h15);
      push_byte(8'h16);
      release_wr();
      wait_drain("full_drain");

      // Simultaneous push and pop at count 2
      stuck_busy = 1'b1;
      push_byte(8'h21);
      push_byte(8'h22);
      release_wr();
      check("simul_pre_count", 32'(bus_if.count), 32'd2);
      stuck_busy     = 1'b0;
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = 8'h23;
      exp_q.push_back(8'h23);
      @(negedge clk);
      release_wr();
      check("simul_count", 32'(bus_if.count),    32'd2);
      check("simul_start", 32'(bus_if.tx_start), 32'd1);
      wait_drain("simul_drain");

      // Same edge with a full FIFO: push blocked, pop proceeds
      stuck_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_byte(8'h31 + 8'(i));
      end
      release_wr();
      check("fullpop_pre_count", 32'(bus_if.count), 32'd4);
      stuck_busy     = 1'b0;
      bus_if.wr_en   = 1'b1;
      bus_if.wr_data = 8'h35;
      @(negedge clk);
      check("fullpop_count", 32'(bus_if.count),    32'd3);
      check("fullpop_start", 32'(bus_if.tx_start), 32'd1);
      push_byte(8'h35);
      release_wr();
      wait_drain("fullpop_drain");

      // Missing ack: uart_tx model never raises busy
      busy_len = 0;
      push_byte(8'h51);
      push_byte(8'h52);
      release_wr();
      check("noack_first", 32'(bus_if.tx_start), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_if.tx_start && (n < 50));
      check("noack_gap", 32'(n), 32'(ACK_GUARD + 2));
      wait_drain("noack_drain");

      // Reset during WAIT_DONE
      busy_len = 30;
      push_byte(8'h61);
      release_wr();
      @(negedge clk);
      check("rwd_start", 32'(bus_if.tx_start), 32'd1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rwd_tx_start", 32'(bus_if.tx_start), 32'd0);
      check("rwd_tx_data",  32'(bus_if.tx_data),  32'h00);
      check("rwd_count",    32'(bus_if.count),    32'd0);
      check("rwd_empty",    32'(bus_if.empty),    32'd1);
      check("rwd_wr_ready", 32'(bus_if.wr_ready), 32'd1);
      push_byte(8'h62);
      release_wr();
      repeat (3) @(negedge clk);
      check("rwd_hold_count", 32'(bus_if.count), 32'd1);
      wait_drain("rwd_drain");

      // LF handling
      busy_len = 4;
      p0 = pulses;
      push_byte(8'h48);
      push_byte(ASCII_LF);
      release_wr();
      wait_drain("crlf_drain");
`ifdef IO_TX_QUEUE_CRLF_EN
      check("crlf_pulses", 32'(pulses - p0), 32'd3);
`else
      check("crlf_pulses", 32'(pulses - p0), 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
